abro_stim_driver: RTL and testbench

- Stimulus and response end of the A/B/O ABRO handshake; drives the A and B inputs of an ABRO state machine and observes its O output.
- Each accepted command asserts A and B after programmable delays, waits for O to rise, then releases A/B and waits for O to fall.
- Returns a result with measured latency and a status code. Used in the block-level bench and in on-chip self-test.

---
 rtl/abro_stim_driver.sv | 210 +++++++++++++++++++++
 tb/tb_abro_stim_driver.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/abro_stim_driver.sv
// rtl/abro_stim_driver.sv - A/B stimulus driver and O response checker for an ABRO state machine.
// Optional macro ABRO_DRV_STATS_EN adds pass_count/fail_count outputs.
module abro_stim_driver #(
  parameter int DW      = 8,
  parameter int LAT_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [DW-1:0]    cmd_a_delay,
  input  logic [DW-1:0]    cmd_b_delay,
  output logic             A,
  output logic             B,
  input  logic             O,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [1:0]       rsp_code,
  output logic [LAT_W-1:0] rsp_latency,
  output logic [2:0]       dbg_state
`ifdef ABRO_DRV_STATS_EN
  ,
  output logic [15:0]      pass_count,
  output logic [15:0]      fail_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_WAIT_O  = 3'd2,
    S_RELEASE = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  localparam logic [1:0]       CODE_PASS    = 2'd0;
  localparam logic [1:0]       CODE_TIMEOUT = 2'd1;
  localparam logic [1:0]       CODE_EARLY   = 2'd2;
  localparam logic [1:0]       CODE_STUCK   = 2'd3;
  localparam logic [LAT_W-1:0] TO_VAL       = LAT_W'(TIMEOUT);

  state_t           r_state;
  state_t           w_next;

  logic [DW-1:0]    r_a_dly;
  logic [DW-1:0]    r_b_dly;
  logic [DW-1:0]    r_cnt;
  logic [LAT_W-1:0] r_lat;
  logic [LAT_W-1:0] r_wcnt;
  logic             r_a;
  logic             r_b;
  logic             r_early;
  logic             r_timeout;
  logic             r_stuck;
  logic             r_rsp_valid;
  logic [1:0]       r_rsp_code;
  logic [LAT_W-1:0] r_rsp_latency;

  logic             w_a_nxt;
  logic             w_b_nxt;
  logic [LAT_W-1:0] w_lat_inc;
  logic [LAT_W-1:0] w_wcnt_inc;
  logic             w_wait_to;
  logic             w_rel_done;
  logic             w_rel_stuck;
  logic [1:0]       w_code;

  assign w_a_nxt     = r_a | (r_cnt == r_a_dly);
  assign w_b_nxt     = r_b | (r_cnt == r_b_dly);
  assign w_lat_inc   = r_lat + LAT_W'(1);
  assign w_wcnt_inc  = r_wcnt + LAT_W'(1);
  assign w_wait_to   = !O && (w_lat_inc == TO_VAL);
  // O must be seen low at least one edge after A/B were dropped
  assign w_rel_done  = !O && (r_wcnt != '0);
  assign w_rel_stuck = O && (w_wcnt_inc == TO_VAL);

  always_comb begin
    w_code = CODE_PASS;
    if (r_early)
      w_code = CODE_EARLY;
    else if (r_timeout)
      w_code = CODE_TIMEOUT;
    else if (r_stuck || w_rel_stuck)
      w_code = CODE_STUCK;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (cmd_valid) w_next = S_RUN;
      S_RUN:     if (w_a_nxt && w_b_nxt) w_next = S_WAIT_O;
      S_WAIT_O:  if (O || w_wait_to) w_next = S_RELEASE;
      S_RELEASE: if (w_rel_done || w_rel_stuck) w_next = S_RESP;
      S_RESP:    if (r_rsp_valid && rsp_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a_dly       <= '0;
      r_b_dly       <= '0;
      r_cnt         <= '0;
      r_lat         <= '0;
      r_wcnt        <= '0;
      r_a           <= 1'b0;
      r_b           <= 1'b0;
      r_early       <= 1'b0;
      r_timeout     <= 1'b0;
      r_stuck       <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_code    <= '0;
      r_rsp_latency <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_a <= 1'b0;
          r_b <= 1'b0;
          if (cmd_valid) begin
            r_a_dly   <= cmd_a_delay;
            r_b_dly   <= cmd_b_delay;
            r_cnt     <= '0;
            r_early   <= 1'b0;
            r_timeout <= 1'b0;
            r_stuck   <= 1'b0;
          end
        end
        S_RUN: begin
          r_a <= w_a_nxt;
          r_b <= w_b_nxt;
          if (r_cnt != '1)
            r_cnt <= r_cnt + DW'(1);
          if (O)
            r_early <= 1'b1;
          if (w_a_nxt && w_b_nxt)
            r_lat <= '0;
        end
        S_WAIT_O: begin
          if (O || w_wait_to) begin
            r_rsp_latency <= O ? w_lat_inc : TO_VAL;
            r_timeout     <= !O;
            r_a           <= 1'b0;
            r_b           <= 1'b0;
            r_wcnt        <= '0;
          end else begin
            r_lat <= w_lat_inc;
          end
        end
        S_RELEASE: begin
          if (w_rel_done || w_rel_stuck) begin
            r_stuck     <= w_rel_stuck;
            r_rsp_valid <= 1'b1;
            r_rsp_code  <= w_code;
          end else begin
            r_wcnt <= w_wcnt_inc;
          end
        end
        S_RESP: begin
          if (r_rsp_valid && rsp_ready)
            r_rsp_valid <= 1'b0;
        end
        default: begin
          r_a         <= 1'b0;
          r_b         <= 1'b0;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef ABRO_DRV_STATS_EN
  logic [15:0] r_pass_cnt;
  logic [15:0] r_fail_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
    end else if (r_state == S_RESP && r_rsp_valid && rsp_ready) begin
      if (r_rsp_code == CODE_PASS) begin
        if (r_pass_cnt != 16'hFFFF)
          r_pass_cnt <= r_pass_cnt + 16'd1;
      end else begin
        if (r_fail_cnt != 16'hFFFF)
          r_fail_cnt <= r_fail_cnt + 16'd1;
      end
    end
  end

  assign pass_count = r_pass_cnt;
  assign fail_count = r_fail_cnt;
`endif

  assign cmd_ready   = (r_state == S_IDLE);
  assign A           = r_a;
  assign B           = r_b;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_code    = r_rsp_code;
  assign rsp_latency = r_rsp_latency;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_abro_stim_driver.sv
// tb/tb_abro_stim_driver.sv - scoreboard bench for abro_stim_driver with a selectable O model.
module tb_abro_stim_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_a_delay;
  logic [7:0] cmd_b_delay;
  logic       A;
  logic       B;
  logic       O;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [1:0] rsp_code;
  logic [7:0] rsp_latency;
  logic [2:0] dbg_state;
`ifdef ABRO_DRV_STATS_EN
  logic [15:0] pass_count;
  logic [15:0] fail_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // O model: 0 = A&B, 1 = tied 0, 2 = tied 1, 3 = A&B registered once
  int   o_mode = 0;
  logic o_reg = 1'b0;
  always @(posedge clk) o_reg <= A & B;
  assign O = (o_mode == 2) ? 1'b1 : (o_mode == 1) ? 1'b0 : (o_mode == 3) ? o_reg : (A & B);

  typedef struct packed {
    logic [1:0] code;
    logic [7:0] lat;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  abro_stim_driver #(.DW(8), .LAT_W(8), .TIMEOUT(16)) dut (
    .clk(clk),
    .reset(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_a_delay(cmd_a_delay),
    .cmd_b_delay(cmd_b_delay),
    .A(A),
    .B(B),
    .O(O),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_code(rsp_code),
    .rsp_latency(rsp_latency),
    .dbg_state(dbg_state)
`ifdef ABRO_DRV_STATS_EN
    ,
    .pass_count(pass_count),
    .fail_count(fail_count)
`endif
  );

  task automatic check_eq(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("rsp_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("rsp_code", rsp_code, e.code);
        check_eq("rsp_latency", rsp_latency, e.lat);
      end
    end
  end

  task automatic send_cmd(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    while (!cmd_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("cmd_ready_wait", cmd_ready, 1);
    cmd_valid   = 1'b1;
    cmd_a_delay = a;
    cmd_b_delay = b;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!cmd_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("idle_return", cmd_ready, 1);
  endtask

  task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [1:0] code,
                         input logic [7:0] lat, input int ea, input int eb, input bit chk_rel);
    exp_t e;
    int   ta = -1;
    int   tb = -1;
    e.code = code;
    e.lat  = lat;
    exp_q.push_back(e);
    send_cmd(a, b);
    for (int k = 1; k <= 60 && (ta < 0 || tb < 0); k++) begin
      @(posedge clk); #1;
      if (A && ta < 0) ta = k;
      if (B && tb < 0) tb = k;
    end
    check_eq("a_rise_edge", ta, ea);
    check_eq("b_rise_edge", tb, eb);
    check_eq("state_wait_o", dbg_state, 2);
    if (chk_rel) begin
      @(posedge clk); #1;
      check_eq("state_release", dbg_state, 3);
      check_eq("a_released", A, 0);
      check_eq("o_fell", O, 0);
    end
    wait_idle();
    check_eq("a_idle", A, 0);
    check_eq("b_idle", B, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int highs;
    exp_t e;
    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_a_delay = '0;
    cmd_b_delay = '0;
    rsp_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check_eq("rst_cmd_ready", cmd_ready, 1);
    check_eq("rst_a", A, 0);
    check_eq("rst_b", B, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_code", rsp_code, 0);
    check_eq("rst_rsp_latency", rsp_latency, 0);
    check_eq("rst_state", dbg_state, 0);
    @(posedge clk); #1;

    o_mode = 0; run_cmd(8'd2, 8'd5, 2'd0, 8'd1, 3, 6, 1'b1);
    o_mode = 0; run_cmd(8'd0, 8'd0, 2'd0, 8'd1, 1, 1, 1'b0);
    o_mode = 3; run_cmd(8'd4, 8'd1, 2'd0, 8'd2, 5, 2, 1'b0);
    o_mode = 0; run_cmd(8'd3, 8'd3, 2'd0, 8'd1, 4, 4, 1'b0);
    o_mode = 1; run_cmd(8'd1, 8'd1, 2'd1, 8'd16, 2, 2, 1'b0);
    o_mode = 2; run_cmd(8'd0, 8'd3, 2'd2, 8'd1, 1, 4, 1'b0);

    // response back-pressure
    o_mode    = 0;
    rsp_ready = 1'b0;
    e.code    = 2'd0;
    e.lat     = 8'd1;
    exp_q.push_back(e);
    send_cmd(8'd1, 8'd2);
    for (int n = 0; n < 100 && !rsp_valid; n++) begin
      @(posedge clk); #1;
    end
    check_eq("hold_rsp_seen", rsp_valid, 1);
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      check_eq("hold_valid", rsp_valid, 1);
      check_eq("hold_code", rsp_code, 0);
      check_eq("hold_latency", rsp_latency, 1);
      check_eq("hold_cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("hold_released", rsp_valid, 0);
    check_eq("hold_idle", dbg_state, 0);
    wait_idle();

`ifdef ABRO_DRV_STATS_EN
    check_eq("pass_count", pass_count, 5);
    check_eq("fail_count", fail_count, 2);
`endif

    // reset in the middle of WAIT_O
    o_mode = 1;
    send_cmd(8'd0, 8'd0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("mid_state_wait_o", dbg_state, 2);
    check_eq("mid_a_high", A, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_a", A, 0);
    check_eq("mid_rst_b", B, 0);
    check_eq("mid_rst_valid", rsp_valid, 0);
    check_eq("mid_rst_state", dbg_state, 0);
`ifdef ABRO_DRV_STATS_EN
    check_eq("mid_rst_pass_count", pass_count, 0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    o_mode = 0;
    highs  = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (rsp_valid) highs++;
    end
    check_eq("no_rsp_after_reset", highs, 0);
    check_eq("post_rst_ready", cmd_ready, 1);
    check_eq("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
